// File: rtl/triad_frame_arbiter.sv
// Round-robin aggregator: grants one completed triad frame at a time to the UART
// transmitter, tags it with {triad_id, seq}, and releases the triad's parser on ack or timeout.
module triad_frame_arbiter #(
  parameter int N_TRIADS    = 4,
  parameter int FRAME_W     = 102,
  parameter int ID_W        = 2,
  parameter int SEQ_W       = 8,
  parameter int ACK_TIMEOUT = 65535
) (
  input  logic                          clk_12MHz,
  input  logic                          reset,
  input  logic [N_TRIADS-1:0]           data_avl,
  input  logic [N_TRIADS*FRAME_W-1:0]   sensor_iterations,
  output logic [N_TRIADS-1:0]           reset_parser,
  output logic                          tx_data_availible,
  output logic [ID_W+SEQ_W+FRAME_W-1:0] tx_frame,
  input  logic                          tx_done,
  output logic [ID_W-1:0]               active_triad,
  output logic [15:0]                   timeout_count
);

  localparam int TX_W  = ID_W + SEQ_W + FRAME_W;
  localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

  state_t               state, state_nxt;
  logic [ID_W-1:0]      rr_ptr, rr_nxt;
  logic [TMR_W-1:0]     timer, timer_nxt;
  logic [SEQ_W-1:0]     seq [N_TRIADS];
  logic                 seq_inc;

  logic                 grant_valid;
  logic [ID_W-1:0]      grant_idx;

  logic [N_TRIADS-1:0]  rp_nxt;
  logic                 dav_nxt;
  logic [TX_W-1:0]      frame_nxt;
  logic [ID_W-1:0]      active_nxt;
  logic [15:0]          tcnt_nxt;
  logic                 release_evt;

  // Circular first-one search starting at rr_ptr.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < N_TRIADS; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_TRIADS) idx = idx - N_TRIADS;
      if (!grant_valid && data_avl[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  assign release_evt = (state == SEND) && (tx_done || (timer == TMR_LAST));

  // State register.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_12MHz) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_valid) state_nxt = SEND;
      SEND:    if (release_evt) state_nxt = RELEASE;
      RELEASE: if (!tx_done)    state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Output and datapath next-values; everything visible outside is registered below.
  always_comb begin
    frame_nxt  = tx_frame;
    dav_nxt    = tx_data_availible;
    active_nxt = active_triad;
    rp_nxt     = '0;
    tcnt_nxt   = timeout_count;
    timer_nxt  = timer;
    rr_nxt     = rr_ptr;
    seq_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          frame_nxt  = {grant_idx, seq[grant_idx],
                        sensor_iterations[int'(grant_idx)*FRAME_W +: FRAME_W]};
          active_nxt = grant_idx;
          dav_nxt    = 1'b1;
          timer_nxt  = '0;
        end
      end
      SEND: begin
        if (release_evt) begin
          dav_nxt = 1'b0;
          rp_nxt  = N_TRIADS'(1) << active_triad;
          seq_inc = 1'b1;
          rr_nxt  = (int'(active_triad) == N_TRIADS - 1) ? '0 : active_triad + ID_W'(1);
          // An ack on the expiry cycle wins, so only a true timeout is counted.
          if (!tx_done && (timeout_count != 16'hFFFF))
            tcnt_nxt = timeout_count + 16'd1;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath state.
  // NOTE: the per-triad seq file is tiny and must restart at 0, so it is reset like any flop.
  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      reset_parser      <= '0;
      tx_data_availible <= 1'b0;
      tx_frame          <= '0;
      active_triad      <= '0;
      timeout_count     <= '0;
      rr_ptr            <= '0;
      timer             <= '0;
      for (int k = 0; k < N_TRIADS; k++) seq[k] <= '0;
    end else begin
      reset_parser      <= rp_nxt;
      tx_data_availible <= dav_nxt;
      tx_frame          <= frame_nxt;
      active_triad      <= active_nxt;
      timeout_count     <= tcnt_nxt;
      rr_ptr            <= rr_nxt;
      timer             <= timer_nxt;
      if (seq_inc) seq[active_triad] <= seq[active_triad] + SEQ_W'(1);
    end
  end

endmodule
